// File: rtl/irrigation_controller.sv
// rtl/irrigation_controller.sv - tick-driven irrigation controller with tank fill hysteresis and optional cleaning cycle
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   nivel      tank sensors {alto,medio,baixo}, 1 = water present
//   solo_seco  1 = soil dry
//   temp_alta  1 = high ambient temperature
//   rega       00 off, 01 sprinkler, 10 drip
//   limpeza    bit1 cleaning active, bit0 cleaning pending
//   erro       sensor fault
//   VE         tank fill valve open
//
// Macro IRRIGATION_CLEAN_EN enables the cleaning cycle (LIMPEZA state,
// session counter, clean timer). Without it limpeza is tied to 00.

module irrigation_controller #(
   parameter int PRESCALE    = 50000000,
   parameter int CLEAN_AFTER = 4,
   parameter int CLEAN_TICKS = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] nivel,
   input  logic       solo_seco,
   input  logic       temp_alta,
   output logic [1:0] rega,
   output logic [1:0] limpeza,
   output logic       erro,
   output logic       VE
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [2:0] {
      IDLE, ASPERSAO, GOTEJAMENTO, ERRO
`ifdef IRRIGATION_CLEAN_EN
      , LIMPEZA
`endif
   } state_t;

   state_t state, state_nx;

   // two-flop synchronizers
   logic [2:0] nivel_m, nivel_s;
   logic       seco_m, seco_s, temp_m, temp_s;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         nivel_m <= '0;
         nivel_s <= '0;
         seco_m  <= 1'b0;
         seco_s  <= 1'b0;
         temp_m  <= 1'b0;
         temp_s  <= 1'b0;
      end else begin
         nivel_m <= nivel;
         nivel_s <= nivel_m;
         seco_m  <= solo_seco;
         seco_s  <= seco_m;
         temp_m  <= temp_alta;
         temp_s  <= temp_m;
      end
   end

   // decision tick prescaler
   logic [PW-1:0] pre_cnt;
   logic          tick;

   assign tick = (pre_cnt == PW'(PRESCALE - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) pre_cnt <= '0;
      else       pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
   end

   // a consistent tank reading fills from the bottom up
   logic valid;
   assign valid = (nivel_s == 3'b000) || (nivel_s == 3'b001) ||
                  (nivel_s == 3'b011) || (nivel_s == 3'b111);

   logic [1:0] rega_nx;
   logic       erro_nx, ve_nx;

`ifdef IRRIGATION_CLEAN_EN
   localparam int SW = $clog2(CLEAN_AFTER + 1);
   localparam int TW = (CLEAN_TICKS > 1) ? $clog2(CLEAN_TICKS) : 1;

   logic [SW-1:0] sessions, sessions_nx;
   logic [TW-1:0] clean_tmr, clean_tmr_nx;
   logic          pending, pending_nx;
`else
   logic unused_clean_cfg;
   assign unused_clean_cfg = |{CLEAN_AFTER, CLEAN_TICKS};
`endif

   always_comb begin
      state_nx = state;
      rega_nx  = rega;
      erro_nx  = erro;
      ve_nx    = VE;
`ifdef IRRIGATION_CLEAN_EN
      sessions_nx  = sessions;
      clean_tmr_nx = clean_tmr;
      pending_nx   = pending;
`endif
      if (tick) begin
         if (!valid) begin
            state_nx = ERRO;
            rega_nx  = 2'b00;
            erro_nx  = 1'b1;
            ve_nx    = 1'b0;
         end else begin
            erro_nx = 1'b0;
            // fill valve hysteresis: open below medio, close at alto
            ve_nx = !nivel_s[1] ? 1'b1 : (nivel_s[2] ? 1'b0 : VE);
            case (state)
               IDLE: begin
`ifdef IRRIGATION_CLEAN_EN
                  if (pending) begin
                     state_nx     = LIMPEZA;
                     pending_nx   = 1'b0;
                     clean_tmr_nx = '0;
                  end else
`endif
                  if (seco_s && nivel_s[0])
                     state_nx = temp_s ? ASPERSAO : GOTEJAMENTO;
               end
               ASPERSAO, GOTEJAMENTO: begin
                  if (!seco_s || !nivel_s[0]) begin
                     state_nx = IDLE;
`ifdef IRRIGATION_CLEAN_EN
                     if (sessions != SW'(CLEAN_AFTER))
                        sessions_nx = sessions + 1'b1;
                     if (sessions_nx == SW'(CLEAN_AFTER))
                        pending_nx = 1'b1;
`endif
                  end else begin
                     state_nx = temp_s ? ASPERSAO : GOTEJAMENTO;
                  end
               end
`ifdef IRRIGATION_CLEAN_EN
               LIMPEZA: begin
                  if (clean_tmr == TW'(CLEAN_TICKS - 1)) begin
                     state_nx    = IDLE;
                     sessions_nx = '0;
                  end else begin
                     clean_tmr_nx = clean_tmr + 1'b1;
                  end
               end
`endif
               ERRO:    state_nx = IDLE;
               default: state_nx = IDLE;
            endcase
            rega_nx = (state_nx == ASPERSAO)    ? 2'b01 :
                      (state_nx == GOTEJAMENTO) ? 2'b10 : 2'b00;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         rega  <= 2'b00;
         erro  <= 1'b0;
         VE    <= 1'b0;
`ifdef IRRIGATION_CLEAN_EN
         sessions  <= '0;
         clean_tmr <= '0;
         pending   <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         rega  <= rega_nx;
         erro  <= erro_nx;
         VE    <= ve_nx;
`ifdef IRRIGATION_CLEAN_EN
         sessions  <= sessions_nx;
         clean_tmr <= clean_tmr_nx;
         pending   <= pending_nx;
`endif
      end
   end

`ifdef IRRIGATION_CLEAN_EN
   assign limpeza = {state == LIMPEZA, pending};
`else
   assign limpeza = 2'b00;
`endif

endmodule
